// File: rtl/uart_fifo_transceiver_if.sv
// Bus bundle for uart_fifo_transceiver: the CPU-side TX/RX valid/ready pairs,
// status flags and the two serial pins. Signal prefixes follow the
// transceiver's point of view (i_ = into the transceiver, o_ = out of it).
//   slave  : the transceiver side
//   master : the CPU glue / bench side
interface uart_fifo_transceiver_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] i_tx_data;
  logic                 i_tx_valid;
  logic                 o_tx_ready;
  logic                 o_tx_busy;
  logic                 o_uart_tx;
  logic                 i_uart_rx;
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_rx_valid;
  logic                 i_rx_ready;
  logic                 o_rx_overrun;
  logic                 i_clr_overrun;
  logic                 o_rx_frame_err;

  modport slave (
    input  i_tx_data, i_tx_valid, i_uart_rx, i_rx_ready, i_clr_overrun,
    output o_tx_ready, o_tx_busy, o_uart_tx, o_rx_data, o_rx_valid,
           o_rx_overrun, o_rx_frame_err
  );

  modport master (
    output i_tx_data, i_tx_valid, i_uart_rx, i_rx_ready, i_clr_overrun,
    input  o_tx_ready, o_tx_busy, o_uart_tx, o_rx_data, o_rx_valid,
           o_rx_overrun, o_rx_frame_err
  );
endinterface

// File: rtl/uart_fifo_transceiver.sv
// Full-duplex UART with independent TX and RX FIFOs.
//   Frame: 1 start bit, DATA_BITS data bits LSB first, no parity, 1 stop bit.
//   Each bit lasts DIV = CLK_FREQ_HZ/BAUD_RATE clocks.
// Ports:
//   i_clk  system clock
//   i_rst  synchronous active-high reset
//   bus    uart_fifo_transceiver_if.slave
//          TX: i_tx_data/i_tx_valid/o_tx_ready push, o_tx_busy, o_uart_tx
//          RX: i_uart_rx (async), o_rx_data/o_rx_valid/i_rx_ready pop (FWFT),
//              o_rx_overrun (sticky, cleared by i_clr_overrun), o_rx_frame_err (pulse)
module uart_fifo_transceiver #(
  parameter int CLK_FREQ_HZ = 27_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16
) (
  input logic                    i_clk,
  input logic                    i_rst,
  uart_fifo_transceiver_if.slave bus
);
  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [PW-1:0]        tx_wr, tx_rd;
  logic                 tx_full, tx_empty, tx_push, tx_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
  assign tx_push  = bus.i_tx_valid && !tx_full;
  assign bus.o_tx_ready = !tx_full;

  // NOTE: storage arrays carry no reset; the pointers alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= bus.i_tx_data;
  end

  // NOTE: all clocked state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PW'(1);
    end
  end

  // ---------------- TX FSM ----------------
  state_t               tx_state, tx_state_nx;
  logic [CW-1:0]        tx_cnt, tx_cnt_nx;
  logic [BW-1:0]        tx_bit, tx_bit_nx;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_nx;
  logic                 tx_last;

  assign tx_last = (tx_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      tx_shift <= tx_shift_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_bit_nx   = tx_bit;
    tx_shift_nx = tx_shift;
    tx_pop      = 1'b0;
    case (tx_state)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop      = 1'b1;
          tx_shift_nx = tx_mem[tx_rd[AW-1:0]];
          tx_cnt_nx   = '0;
          tx_state_nx = START;
        end
      end
      START: begin
        if (tx_last) begin
          tx_cnt_nx   = '0;
          tx_bit_nx   = '0;
          tx_state_nx = DATA;
        end else begin
          tx_cnt_nx = tx_cnt + CW'(1);
        end
      end
      DATA: begin
        if (tx_last) begin
          tx_cnt_nx   = '0;
          tx_shift_nx = {1'b0, tx_shift[DATA_BITS-1:1]};
          if (tx_bit == BIT_LAST) tx_state_nx = STOP;
          else                    tx_bit_nx   = tx_bit + BW'(1);
        end else begin
          tx_cnt_nx = tx_cnt + CW'(1);
        end
      end
      STOP: begin
        if (tx_last) begin
          tx_cnt_nx = '0;
          // Chain straight into the next start bit so queued frames abut.
          if (!tx_empty) begin
            tx_pop      = 1'b1;
            tx_shift_nx = tx_mem[tx_rd[AW-1:0]];
            tx_state_nx = START;
          end else begin
            tx_state_nx = IDLE;
          end
        end else begin
          tx_cnt_nx = tx_cnt + CW'(1);
        end
      end
    endcase
  end

  assign bus.o_uart_tx = (tx_state == START) ? 1'b0 :
                         (tx_state == DATA)  ? tx_shift[0] : 1'b1;
  assign bus.o_tx_busy = !tx_empty || (tx_state != IDLE);

  // ---------------- RX synchroniser ----------------
  // rx_s2 is the synchronised line; rx_prev is one more stage for edge detection.
  logic rx_s1, rx_s2, rx_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= bus.i_uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // ---------------- RX FSM ----------------
  state_t               rx_state, rx_state_nx;
  logic [CW-1:0]        rx_cnt, rx_cnt_nx;
  logic [BW-1:0]        rx_bit, rx_bit_nx;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_nx;
  logic                 rx_last, rx_stop_ok, rx_stop_bad;

  assign rx_last = (rx_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      rx_shift <= rx_shift_nx;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_stop_ok  = 1'b0;
    rx_stop_bad = 1'b0;
    case (rx_state)
      IDLE: begin
        // A genuine falling edge is required, so a line held low after a
        // break or bad stop bit must return high before a new frame starts.
        if (rx_prev && !rx_s2) begin
          rx_cnt_nx   = '0;
          rx_state_nx = START;
        end
      end
      START: begin
        if (rx_cnt == CNT_HALF) begin
          rx_cnt_nx = '0;
          rx_bit_nx = '0;
          rx_state_nx = rx_s2 ? IDLE : DATA;
        end else begin
          rx_cnt_nx = rx_cnt + CW'(1);
        end
      end
      DATA: begin
        if (rx_last) begin
          rx_cnt_nx   = '0;
          rx_shift_nx = {rx_s2, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == BIT_LAST) rx_state_nx = STOP;
          else                    rx_bit_nx   = rx_bit + BW'(1);
        end else begin
          rx_cnt_nx = rx_cnt + CW'(1);
        end
      end
      STOP: begin
        if (rx_last) begin
          rx_cnt_nx   = '0;
          rx_state_nx = IDLE;
          rx_stop_ok  = rx_s2;
          rx_stop_bad = !rx_s2;
        end else begin
          rx_cnt_nx = rx_cnt + CW'(1);
        end
      end
    endcase
  end

  // ---------------- RX FIFO + flags ----------------
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0]        rx_wr, rx_rd;
  logic                 rx_full, rx_empty, rx_push, rx_pop, rx_overrun, rx_frame_err;

  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign rx_pop   = !rx_empty && bus.i_rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign rx_push  = rx_stop_ok && (!rx_full || rx_pop);

  always_ff @(posedge i_clk) begin
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_wr        <= '0;
      rx_rd        <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + PW'(1);
      if (rx_pop)  rx_rd <= rx_rd + PW'(1);
      // Setting wins over a simultaneous clear so no drop goes unreported.
      if (rx_stop_ok && !rx_push) rx_overrun <= 1'b1;
      else if (bus.i_clr_overrun) rx_overrun <= 1'b0;
      rx_frame_err <= rx_stop_bad;
    end
  end

  assign bus.o_rx_data      = rx_mem[rx_rd[AW-1:0]];
  assign bus.o_rx_valid     = !rx_empty;
  assign bus.o_rx_overrun   = rx_overrun;
  assign bus.o_rx_frame_err = rx_frame_err;
endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// Self-checking bench for uart_fifo_transceiver (DIV=10, 8 data bits, depth 16).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_uart_fifo_transceiver;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int NB     = 8;
  localparam int DEPTH  = 16;
  localparam int FRAME  = DIV * (NB + 2);

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic loop_en  = 1'b0;
  logic rx_drive = 1'b1;
  int   total    = 0;
  int   bad      = 0;

  uart_fifo_transceiver_if #(.DATA_BITS(NB)) bus ();

  assign bus.i_uart_rx = loop_en ? bus.o_uart_tx : rx_drive;

  uart_fifo_transceiver #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD),
    .DATA_BITS  (NB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level k cycles after the push cycle of a frame sent from idle.
  function automatic logic line_model(input int k, input logic [NB-1:0] b);
    int slot;
    if (k < 2) return 1'b1;
    slot = (k - 2) / DIV;
    if (slot == 0) return 1'b0;
    if (slot <= NB) return b[slot-1];
    return 1'b1;
  endfunction

  task automatic do_reset(input string tag);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_uart_tx"},   bus.o_uart_tx,      1'b1);
    check({tag, "_tx_ready"},  bus.o_tx_ready,     1'b1);
    check({tag, "_tx_busy"},   bus.o_tx_busy,      1'b0);
    check({tag, "_rx_valid"},  bus.o_rx_valid,     1'b0);
    check({tag, "_overrun"},   bus.o_rx_overrun,   1'b0);
    check({tag, "_frame_err"}, bus.o_rx_frame_err, 1'b0);
  endtask

  task automatic test_tx_single(input logic [NB-1:0] b);
    for (int k = 0; k <= FRAME + 10; k++) begin
      step();
      bus.i_tx_valid = (k == 0);
      bus.i_tx_data  = (k == 0) ? b : NB'($urandom);
      @(negedge clk);
      check("t1_line", bus.o_uart_tx, line_model(k, b));
      check("t1_busy", bus.o_tx_busy, (k >= 1) && (k <= FRAME + 1));
    end
  endtask

  task automatic test_loopback(input int n_rand);
    logic [NB-1:0] sent[$];
    logic [NB-1:0] expq[$];
    int n, got, errs, limit;
    sent = '{8'h00, 8'hFF, 8'hA5};
    repeat (n_rand) sent.push_back(NB'($urandom));
    n     = sent.size();
    expq  = sent;
    got   = 0;
    errs  = 0;
    limit = 2 + FRAME * n + 60;
    loop_en = 1'b1;
    for (int i = 0; i <= limit; i++) begin
      step();
      bus.i_tx_valid = (i < n);
      bus.i_tx_data  = (i < n) ? sent[i] : NB'($urandom);
      bus.i_rx_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (i < n) check("t2_tx_ready", bus.o_tx_ready, 1'b1);
      if (i >= 1 && i <= 2 + FRAME * n)
        check("t2_busy", bus.o_tx_busy, i <= 1 + FRAME * n);
      if (bus.o_rx_frame_err) errs++;
      if (bus.o_rx_valid && bus.i_rx_ready) begin
        got++;
        if (expq.size() > 0) check("t2_data", bus.o_rx_data, expq.pop_front());
      end
    end
    check("t2_count",     got,              n);
    check("t2_frame_err", errs,             0);
    check("t2_overrun",   bus.o_rx_overrun, 1'b0);
    check("t2_empty",     bus.o_rx_valid,   1'b0);
    step();
    bus.i_rx_ready = 1'b0;
    loop_en        = 1'b0;
  endtask

  task automatic test_tx_full();
    int acc = 0;
    for (int i = 0; i <= FRAME + 2; i++) begin
      step();
      bus.i_tx_valid = (i < 20);
      bus.i_tx_data  = NB'(i);
      @(negedge clk);
      if (bus.i_tx_valid && bus.o_tx_ready) acc++;
      if (i == 25) check("t3_accepted", acc, 17);
      if (i >= 17) check("t3_ready", bus.o_tx_ready, i >= FRAME + 2);
    end
  endtask

  task automatic test_overrun();
    logic [NB-1:0] sent[$];
    int acc  = 0;
    int errs = 0;
    for (int k = 0; k < 17; k++) sent.push_back(NB'($urandom));
    loop_en        = 1'b1;
    bus.i_rx_ready = 1'b0;
    for (int i = 0; i <= 17 * FRAME + 20; i++) begin
      step();
      bus.i_tx_valid = (i < 17);
      bus.i_tx_data  = (i < 17) ? sent[i] : '0;
      @(negedge clk);
      if (bus.i_tx_valid && bus.o_tx_ready) acc++;
      if (bus.o_rx_frame_err) errs++;
      if (i == 16 * FRAME + 50) check("t4_no_ovr_yet", bus.o_rx_overrun, 1'b0);
    end
    check("t4_accepted", acc,              17);
    check("t4_overrun",  bus.o_rx_overrun, 1'b1);
    check("t4_frame_err", errs,            0);
    step();
    bus.i_clr_overrun = 1'b1;
    step();
    bus.i_clr_overrun = 1'b0;
    @(negedge clk);
    check("t4_cleared", bus.o_rx_overrun, 1'b0);
    for (int k = 0; k < 16; k++) begin
      step();
      bus.i_rx_ready = 1'b1;
      @(negedge clk);
      check("t4_valid", bus.o_rx_valid, 1'b1);
      check("t4_data",  bus.o_rx_data,  sent[k]);
    end
    step();
    bus.i_rx_ready = 1'b0;
    @(negedge clk);
    check("t4_17th_absent", bus.o_rx_valid, 1'b0);
    loop_en = 1'b0;
  endtask

  task automatic test_glitch_framing();
    logic [NB-1:0] b = 8'h3C;
    int pulses = 0;
    int valids = 0;
    int slot;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i < 3) begin
        rx_drive = 1'b0;
      end else if (i >= 60 && i < 60 + FRAME) begin
        slot     = (i - 60) / DIV;
        rx_drive = (slot >= 1 && slot <= NB) ? b[slot-1] : 1'b0;
      end else begin
        rx_drive = 1'b1;
      end
      @(negedge clk);
      pulses += int'(bus.o_rx_frame_err);
      if (bus.o_rx_valid) valids++;
      if (i == 59) begin
        check("t5_glitch_err",   pulses, 0);
        check("t5_glitch_valid", valids, 0);
      end
    end
    check("t5_frame_err_pulses", pulses, 1);
    check("t5_rx_valid",         valids, 0);
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i <= 30; i++) begin
      step();
      bus.i_tx_valid = (i < 3);
      bus.i_tx_data  = NB'($urandom);
      @(negedge clk);
    end
    do_reset("t6");
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      @(negedge clk);
      check("t6_line_idle", bus.o_uart_tx, 1'b1);
    end
    check("t6_busy", bus.o_tx_busy, 1'b0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_tx_valid    = 1'b0;
    bus.i_tx_data     = '0;
    bus.i_rx_ready    = 1'b0;
    bus.i_clr_overrun = 1'b0;
    repeat (3) @(posedge clk);
    do_reset("rst");
    test_tx_single(8'h55);
    test_tx_single(NB'($urandom));
    test_tx_single(NB'($urandom));
    test_loopback(5);
    test_tx_full();
    do_reset("t3_rst");
    test_overrun();
    test_glitch_framing();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
